// File: rtl/ram_prog_loader_if.sv
// Bus bundle between the serial host side (master) and the program loader (slave).
// The chk_err signal exists only when CHECKSUM_EN is defined.
interface ram_prog_loader_if #(
  parameter int ADDR_W = 4
);
  logic              rx;
  logic              start;
  logic              prog_mode;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        data;
  logic              wr_en;
  logic              busy;
  logic              done;
  logic              frame_err;
`ifdef CHECKSUM_EN
  logic              chk_err;

  modport master (
    output rx, start,
    input  prog_mode, addr, data, wr_en, busy, done, frame_err, chk_err
  );

  modport slave (
    input  rx, start,
    output prog_mode, addr, data, wr_en, busy, done, frame_err, chk_err
  );
`else
  modport master (
    output rx, start,
    input  prog_mode, addr, data, wr_en, busy, done, frame_err
  );

  modport slave (
    input  rx, start,
    output prog_mode, addr, data, wr_en, busy, done, frame_err
  );
`endif
endinterface

// File: rtl/ram_prog_loader.sv
// UART (8N1) program loader writing DEPTH bytes to the eightBit RAM programming port.
// Optional CHECKSUM_EN: an extra mod-256 checksum byte is received and verified after the image.
module ram_prog_loader #(
  parameter int CLKS_PER_BIT = 104,
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4
) (
  input  logic             fastClk_i,
  input  logic             rst_ni,
  ram_prog_loader_if.slave bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0]  FULL_BIT = CNT_W'(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT, START, DATA, STOP, WRITE, DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bitIdx_q, bitIdx_d;
  logic [7:0]        shift_q, shift_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              done_q, done_d;
  logic              frameErr_q, frameErr_d;
  logic              rxMeta_q, rxSync_q, rxPrev_q;
`ifdef CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
  logic              chkPhase_q, chkPhase_d;
  logic              chkErr_q, chkErr_d;
`endif

  // rxPrev is pinned high while parked so a fall coinciding with start is still seen in WAIT.
  always_ff @(posedge fastClk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
      rxPrev_q <= 1'b1;
    end else begin
      rxMeta_q <= bus.rx;
      rxSync_q <= rxMeta_q;
      rxPrev_q <= (state_q == IDLE || state_q == DONE) ? 1'b1 : rxSync_q;
    end
  end

  always_ff @(posedge fastClk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      frameErr_q <= 1'b0;
`ifdef CHECKSUM_EN
      sum_q      <= '0;
      chkPhase_q <= 1'b0;
      chkErr_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitIdx_q   <= bitIdx_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      done_q     <= done_d;
      frameErr_q <= frameErr_d;
`ifdef CHECKSUM_EN
      sum_q      <= sum_d;
      chkPhase_q <= chkPhase_d;
      chkErr_q   <= chkErr_d;
`endif
    end
  end

  // Bit timing: counters are reloaded on each transition and a sample is taken when they reach 1.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bitIdx_d   = bitIdx_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    data_d     = data_q;
    done_d     = done_q;
    frameErr_d = frameErr_q;
`ifdef CHECKSUM_EN
    sum_d      = sum_q;
    chkPhase_d = chkPhase_q;
    chkErr_d   = chkErr_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d    = WAIT;
          addr_d     = '0;
          done_d     = 1'b0;
          frameErr_d = 1'b0;
`ifdef CHECKSUM_EN
          sum_d      = '0;
          chkPhase_d = 1'b0;
          chkErr_d   = 1'b0;
`endif
        end
      end
      WAIT: begin
        if (!rxSync_q && rxPrev_q) begin
          state_d = START;
          cnt_d   = HALF_BIT;
        end
      end
      START: begin
        if (cnt_q != CNT_W'(1)) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!rxSync_q) begin
          state_d  = DATA;
          cnt_d    = FULL_BIT;
          bitIdx_d = '0;
        end else begin
          state_d = WAIT;
        end
      end
      DATA: begin
        if (cnt_q != CNT_W'(1)) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d  = {rxSync_q, shift_q[7:1]};
          cnt_d    = FULL_BIT;
          bitIdx_d = bitIdx_q + 3'd1;
          if (bitIdx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q != CNT_W'(1)) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!rxSync_q) begin
          frameErr_d = 1'b1;
          state_d    = WAIT;
        end
`ifdef CHECKSUM_EN
        else if (chkPhase_q) begin
          state_d = DONE;
          if (shift_q == sum_q) done_d = 1'b1;
          else chkErr_d = 1'b1;
        end
`endif
        else begin
          state_d = WRITE;
          data_d  = shift_q;
        end
      end
      WRITE: begin
`ifdef CHECKSUM_EN
        sum_d = sum_q + data_q;
`endif
        if (addr_q == LAST) begin
`ifdef CHECKSUM_EN
          chkPhase_d = 1'b1;
          state_d    = WAIT;
`else
          done_d  = 1'b1;
          state_d = DONE;
`endif
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy      = (state_q != IDLE) && (state_q != DONE);
  assign bus.prog_mode = bus.busy;
  assign bus.wr_en     = (state_q == WRITE);
  assign bus.addr      = addr_q;
  assign bus.data      = data_q;
  assign bus.done      = done_q;
  assign bus.frame_err = frameErr_q;
`ifdef CHECKSUM_EN
  assign bus.chk_err   = chkErr_q;
`endif

endmodule
